// File: rtl/timebase_scheduler.sv
// timebase_scheduler
//
// Shared timebase plus NUM_CH independent tick-counting timers. A prescaler
// divides clk by DIV to produce a single-cycle tick enable; no derived clock
// is ever generated. Each channel counts whole ticks and reports expiry as a
// one-cycle expire pulse together with sticky pending/overrun flags.
//
// Ports:
//   clk           system clock
//   reset         asynchronous, active-low reset
//   run           prescaler enable; 0 freezes the prescaler and all channels
//   cfg_valid     single-cycle configuration write strobe
//   cfg_ch        target channel of the write (out-of-range values ignored)
//   cfg_start     1 = arm the channel, 0 = stop it
//   cfg_periodic  1 = auto-reload, 0 = one-shot
//   cfg_period    period in ticks (0 behaves as 1)
//   ack           per-channel clear of pending/overrun
//   tick          one-cycle pulse every DIV clk cycles while run=1
//   expire        one-cycle expiry pulse per channel
//   pending       sticky expiry flag per channel
//   overrun       sticky flag: expiry while pending was already set
//   active        channel is armed
module timebase_scheduler #(
    parameter int DIV    = 50_000_000,
    parameter int DIV_W  = 26,
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 16,
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic              cfg_valid,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic              cfg_start,
    input  logic              cfg_periodic,
    input  logic [CNT_W-1:0]  cfg_period,
    input  logic [NUM_CH-1:0] ack,
    output logic              tick,
    output logic [NUM_CH-1:0] expire,
    output logic [NUM_CH-1:0] pending,
    output logic [NUM_CH-1:0] overrun,
    output logic [NUM_CH-1:0] active
);

    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } ch_state_t;

    localparam logic [DIV_W-1:0] PRESC_LAST = DIV_W'(DIV - 1);

    logic [DIV_W-1:0] presc;

    ch_state_t                     state      [NUM_CH];
    ch_state_t                     state_next [NUM_CH];
    logic [NUM_CH-1:0][CNT_W-1:0]  count;
    logic [NUM_CH-1:0][CNT_W-1:0]  count_next;
    logic [NUM_CH-1:0][CNT_W-1:0]  period_q;
    logic [NUM_CH-1:0][CNT_W-1:0]  period_next;
    logic [NUM_CH-1:0]             periodic_q;
    logic [NUM_CH-1:0]             periodic_next;
    logic [NUM_CH-1:0]             expire_next;
    logic [NUM_CH-1:0]             cfg_hit;
    logic [CNT_W-1:0]              load_val;

    // Prescaler: tick is registered, so it appears the cycle after the
    // counter sits at DIV-1. Dropping run holds the phase rather than
    // resetting it, so resuming continues the interrupted period.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc <= '0;
            tick  <= 1'b0;
        end else if (run) begin
            tick  <= (presc == PRESC_LAST);
            presc <= (presc == PRESC_LAST) ? '0 : presc + 1'b1;
        end else begin
            tick  <= 1'b0;
        end
    end

    // Decode the config strobe per channel; the extra MSB makes any
    // out-of-range channel number match nothing.
    always_comb begin
        cfg_hit = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cfg_hit[i] = cfg_valid && ({1'b0, cfg_ch} == (CH_W + 1)'(i));
        end
        load_val = (cfg_period == '0) ? CNT_W'(1) : cfg_period;
    end

    // Channel next-state logic. A config write takes priority over a
    // coincident tick, so a stop issued on the exhausting tick suppresses
    // the expiry.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            state_next[i]    = state[i];
            count_next[i]    = count[i];
            period_next[i]   = period_q[i];
            periodic_next[i] = periodic_q[i];
            expire_next[i]   = 1'b0;

            if (cfg_hit[i]) begin
                if (cfg_start) begin
                    state_next[i]    = ARMED;
                    count_next[i]    = load_val;
                    period_next[i]   = load_val;
                    periodic_next[i] = cfg_periodic;
                end else begin
                    state_next[i] = IDLE;
                    count_next[i] = '0;
                end
            end else if (state[i] == ARMED && tick) begin
                if (count[i] > CNT_W'(1)) begin
                    count_next[i] = count[i] - 1'b1;
                end else begin
                    expire_next[i] = 1'b1;
                    if (periodic_q[i]) begin
                        count_next[i] = period_q[i];
                    end else begin
                        state_next[i] = IDLE;
                        count_next[i] = '0;
                    end
                end
            end
        end
    end

    // Channel registers; expire and active are registered from the
    // next-state values so they line up with the state change.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                state[i] <= IDLE;
            end
            count      <= '0;
            period_q   <= '0;
            periodic_q <= '0;
            expire     <= '0;
            active     <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                state[i]  <= state_next[i];
                active[i] <= (state_next[i] == ARMED);
            end
            count      <= count_next;
            period_q   <= period_next;
            periodic_q <= periodic_next;
            expire     <= expire_next;
        end
    end

    // Sticky flags follow the expire pulse by one cycle. A set coinciding
    // with an ack wins, and in that case overrun is left untouched.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending <= '0;
            overrun <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (expire[i]) begin
                    pending[i] <= 1'b1;
                    if (pending[i]) begin
                        overrun[i] <= 1'b1;
                    end
                end else if (ack[i]) begin
                    pending[i] <= 1'b0;
                    overrun[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_timebase_scheduler.sv
// tb_timebase_scheduler
//
// Directed bench for timebase_scheduler with DIV=10. Expected tick/expire
// pulses are queued as (cycle, signal) events when the stimulus is applied;
// a negedge monitor drains the queue and compares every cycle. Flags and
// active are checked at chosen points.
module tb_timebase_scheduler;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 8;

    logic              clk;
    logic              reset;
    logic              run;
    logic              cfg_valid;
    logic [1:0]        cfg_ch;
    logic              cfg_start;
    logic              cfg_periodic;
    logic [CNT_W-1:0]  cfg_period;
    logic [NUM_CH-1:0] ack;
    logic              tick;
    logic [NUM_CH-1:0] expire;
    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] overrun;
    logic [NUM_CH-1:0] active;

    timebase_scheduler #(
        .DIV    (10),
        .DIV_W  (4),
        .NUM_CH (NUM_CH),
        .CNT_W  (CNT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .run          (run),
        .cfg_valid    (cfg_valid),
        .cfg_ch       (cfg_ch),
        .cfg_start    (cfg_start),
        .cfg_periodic (cfg_periodic),
        .cfg_period   (cfg_period),
        .ack          (ack),
        .tick         (tick),
        .expire       (expire),
        .pending      (pending),
        .overrun      (overrun),
        .active       (active)
    );

    // Event signal index: 0 = tick, 1+ch = expire[ch].
    typedef struct {
        int cyc;
        int sig;
    } ev_t;

    ev_t  sbq[$];
    int   errors;
    int   checks;
    int   cyc;
    int   t0;
    logic mon_en;
    logic [4:0] mon_exp;
    logic [4:0] mon_obs;
    int   mon_rel;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    task automatic check_output(input string tag, input logic [31:0] obs,
                                input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push_ev(input int c, input int s);
        ev_t e;
        e.cyc = c;
        e.sig = s;
        sbq.push_back(e);
    endtask

    // Wait until #1 after the given posedge, counted from reset release.
    task automatic wait_rel(input int r);
        while ((cyc - t0) < r) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic apply_cfg(input int ch, input logic start,
                             input logic periodic, input int period);
        cfg_valid    = 1'b1;
        cfg_ch       = 2'(ch);
        cfg_start    = start;
        cfg_periodic = periodic;
        cfg_period   = CNT_W'(period);
    endtask

    // Per-cycle pulse comparison against the scoreboard.
    always @(negedge clk) begin
        if (mon_en) begin
            mon_rel = cyc - t0;
            mon_exp = '0;
            for (int i = sbq.size() - 1; i >= 0; i--) begin
                if (sbq[i].cyc == mon_rel) begin
                    mon_exp[sbq[i].sig] = 1'b1;
                    sbq.delete(i);
                end
            end
            mon_obs = {expire, tick};
            check_output($sformatf("pulses@%0d", mon_rel), 32'(mon_obs),
                         32'(mon_exp));
        end
    end

    initial begin
        errors       = 0;
        checks       = 0;
        t0           = 0;
        mon_en       = 1'b0;
        reset        = 1'b0;
        run          = 1'b1;
        cfg_valid    = 1'b0;
        cfg_ch       = '0;
        cfg_start    = 1'b0;
        cfg_periodic = 1'b0;
        cfg_period   = '0;
        ack          = '0;

        repeat (3) @(posedge clk);
        #1;
        check_output("rst_tick",    32'(tick),    32'd0);
        check_output("rst_expire",  32'(expire),  32'd0);
        check_output("rst_pending", 32'(pending), 32'd0);
        check_output("rst_overrun", 32'(overrun), 32'd0);
        check_output("rst_active",  32'(active),  32'd0);

        // Release with run=1: ticks at 10, then run paused 14..20 so the
        // held phase produces the next tick at 26 and every 10 after.
        reset  = 1'b1;
        t0     = cyc;
        mon_en = 1'b1;
        push_ev(10, 0);
        for (int c = 26; c <= 96; c += 10) push_ev(c, 0);

        wait_rel(14);
        run = 1'b0;
        wait_rel(20);
        run = 1'b1;

        // Ticks consumed at edges 37, 47, 57, 67 ...
        wait_rel(30);
        apply_cfg(0, 1'b1, 1'b1, 3);
        push_ev(57, 1);
        push_ev(87, 1);
        wait_rel(31);
        apply_cfg(1, 1'b1, 1'b0, 2);
        push_ev(47, 2);
        wait_rel(32);
        apply_cfg(2, 1'b1, 1'b1, 1);
        push_ev(37, 3);
        push_ev(47, 3);
        push_ev(57, 3);
        wait_rel(33);
        apply_cfg(3, 1'b1, 1'b1, 0);
        push_ev(37, 4);
        push_ev(47, 4);
        push_ev(57, 4);
        wait_rel(34);
        cfg_valid = 1'b0;
        check_output("active_all", 32'(active), 32'hF);

        wait_rel(46);
        check_output("active_pre_oneshot", 32'(active), 32'hF);
        wait_rel(47);
        check_output("active_oneshot_drop", 32'(active), 32'hD);

        wait_rel(48);
        check_output("pending_48", 32'(pending), 32'hE);
        check_output("overrun_48", 32'(overrun), 32'hC);

        wait_rel(50);
        ack = 4'b0100;
        wait_rel(51);
        ack = '0;
        check_output("pending_ack", 32'(pending), 32'hA);
        check_output("overrun_ack", 32'(overrun), 32'h8);

        // Ack coinciding with expire[2]: the set wins.
        wait_rel(57);
        ack = 4'b0100;
        wait_rel(58);
        ack = '0;
        check_output("pending_ack_collide", 32'(pending), 32'hF);
        check_output("overrun_ack_collide", 32'(overrun), 32'h8);

        wait_rel(60);
        apply_cfg(2, 1'b0, 1'b0, 0);
        wait_rel(61);
        cfg_valid = 1'b0;
        check_output("active_stop2", 32'(active), 32'h9);

        // Stop ch3 in the tick cycle that would have expired it.
        wait_rel(66);
        apply_cfg(3, 1'b0, 1'b0, 0);
        wait_rel(67);
        cfg_valid = 1'b0;
        check_output("active_stop3", 32'(active), 32'h1);

        wait_rel(99);
        check_output("pending_99", 32'(pending), 32'hF);
        check_output("overrun_99", 32'(overrun), 32'h9);
        check_output("active_99",  32'(active),  32'h1);

        // Mid-operation reset clears everything asynchronously.
        wait_rel(100);
        reset = 1'b0;
        #1;
        check_output("midrst_tick",    32'(tick),    32'd0);
        check_output("midrst_expire",  32'(expire),  32'd0);
        check_output("midrst_pending", 32'(pending), 32'd0);
        check_output("midrst_overrun", 32'(overrun), 32'd0);
        check_output("midrst_active",  32'(active),  32'd0);
        check_output("sb_drained_1",   32'(sbq.size()), 32'd0);

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        t0    = cyc;
        for (int c = 10; c <= 50; c += 10) push_ev(c, 0);

        wait_rel(40);
        check_output("post_rst_active",  32'(active),  32'd0);
        check_output("post_rst_pending", 32'(pending), 32'd0);

        wait_rel(41);
        apply_cfg(0, 1'b1, 1'b1, 1);
        push_ev(51, 1);
        wait_rel(42);
        cfg_valid = 1'b0;
        check_output("rearm_active", 32'(active), 32'h1);

        wait_rel(53);
        mon_en = 1'b0;
        check_output("sb_drained_2", 32'(sbq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/timebase_scheduler.md
Name: timebase_scheduler

Overview:
- Shared 1 Hz-class timebase with NUM_CH independent software timers for the FPGA practice designs.
- Derives a single-cycle tick enable from clk; it never produces a derived clock.
- Every channel counts whole ticks and reports expiry as a pulse plus a sticky pending flag.
- Sits between the 50 MHz board clock and consumer blocks (blinkers, counters, display refresh), which use tick/expire as clock enables.

Parameters:
- DIV, 50_000_000: tick period in clk cycles, must be >= 2.
- DIV_W, 26: prescaler width, must satisfy 2**DIV_W >= DIV.
- NUM_CH, 4: number of timer channels, 1 to 8.
- CNT_W, 16: channel period/count width.

Ports:
- clk  in  1  system clock (50 MHz).
- reset  in  1  asynchronous, active-low reset.
- run  in  1  prescaler enable; 0 freezes the prescaler and all channels.
- cfg_valid  in  1  single-cycle config write strobe.
- cfg_ch  in  $clog2(NUM_CH) (min 1)  target channel; values >= NUM_CH are ignored.
- cfg_start  in  1  1 = arm the channel, 0 = stop it.
- cfg_periodic  in  1  1 = auto-reload, 0 = one-shot.
- cfg_period  in  CNT_W  period in ticks.
- ack  in  NUM_CH  per-channel clear of pending/overrun.
- tick  out  1  one-cycle pulse every DIV clk cycles while run=1.
- expire  out  NUM_CH  one-cycle expiry pulse per channel.
- pending  out  NUM_CH  sticky expiry flag.
- overrun  out  NUM_CH  sticky flag: expiry occurred while pending was already set.
- active  out  NUM_CH  channel is in ARMED.

Behaviour:
- Reset (reset=0, async):
  - prescaler=0, all channels IDLE, count=0.
  - tick, expire, pending, overrun, active all 0.
- Prescaler:
  - With run=1, counts 0..DIV-1 and wraps to 0.
  - tick is registered: high for the one cycle after the prescaler holds DIV-1, so the first tick is DIV cycles after run rises from reset.
  - With run=0, the prescaler holds its value and tick=0.
  - Resuming run continues from the held value; there is no phase reset.
- Channel FSM, per channel: IDLE, ARMED.
  - IDLE with cfg write, cfg_start=1: load count=max(cfg_period,1), latch mode, go ARMED. A period of 0 behaves as 1.
  - Any state with cfg write, cfg_start=0: go IDLE, count=0. No expire is generated.
  - ARMED with cfg_start=1: restart, reload count and mode.
  - ARMED when tick=1:
    - count > 1: count decrements.
    - count == 1: expire pulses the next cycle. Periodic mode reloads count with the latched period and stays ARMED. One-shot mode goes IDLE.
  - Expiry latency: expire[i] is high for exactly the one cycle following the tick that exhausts the count.
  - A channel armed with period P (periodic) expires every P*DIV cycles.
- active[i] = (state==ARMED), registered.
- Simultaneous events:
  - cfg write and tick on the same channel in the same cycle: the cfg write wins and that tick is not applied to the channel.
  - expire set and ack in the same cycle: set wins; pending stays 1 and overrun is unaffected by the ack.
- Flags:
  - pending[i] is set on expire[i] and cleared by ack[i].
  - overrun[i] is set when expire[i] occurs with pending[i] already 1, and cleared by ack[i].
  - ack on a clear channel has no effect.
- Channels are independent and all advance on the same tick.
- Reset mid-operation: everything returns to reset values immediately. There is no pulse on reset release.

Test Plan:
1. DIV=10, run=1 from reset release -> tick high at cycles 10, 20, 30 after release, each for 1 cycle. Drop run at cycle 14, restore at 20 -> next tick at cycle 26.
2. Ch0 periodic, period 3, armed at cycle 0 -> expire[0] at 30, 60, 90 (+1 registered cycle). Active stays 1. Pending set after the first expire.
3. Ch1 one-shot, period 2 -> single expire[1] after the 2nd tick. Active drops to 0 with it. No further pulses over 10 ticks.
4. Ch2 periodic, period 1, no ack -> pending=1 after the 1st expiry and overrun=1 after the 2nd. Ack for one cycle clears both. Ack on the exact expire cycle leaves pending=1.
5. Arm ch3 with period 0 -> expires after 1 tick. Stop write in the same cycle as a tick that would expire ch3 -> no expire, active=0.
6. Assert reset mid-count with ch0 ARMED and pending=1 -> all outputs 0 immediately. After release, no expire until ch0 is re-armed.
